// File: rtl/gp01_result_serializer_if.sv
// GP01 result serializer bus: capture inputs plus serial line and FIFO status.
// The slave side is the serializer; the master side is whoever drives captures
// and observes the line.
interface gp01_result_serializer_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [5:0]    i_data;
  logic          i_overflow;
  logic          i_capture;
  logic          o_tx;
  logic          o_busy;
  logic [CW-1:0] o_fifo_count;
  logic          o_fifo_full;
  logic          o_drop;

  modport master (
    output i_data,
    output i_overflow,
    output i_capture,
    input  o_tx,
    input  o_busy,
    input  o_fifo_count,
    input  o_fifo_full,
    input  o_drop
  );

  modport slave (
    input  i_data,
    input  i_overflow,
    input  i_capture,
    output o_tx,
    output o_busy,
    output o_fifo_count,
    output o_fifo_full,
    output o_drop
  );
endinterface

// File: rtl/gp01_result_serializer.sv
// GP01 result serializer: captures {overflow, data} samples into a small FIFO
// and sends each one as a 10-bit frame (start, d0..d5, ovf, even parity, stop)
// on a single idle-high line. Frames run back-to-back while the FIFO has data.
module gp01_result_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          i_rst_n,
  gp01_result_serializer_if.slave       bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [7:0]    BAUD_LAST_C = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Even parity over the 7 payload bits (data plus overflow flag).
  function automatic logic parity7(input logic [6:0] payload);
    parity7 = ^payload;
  endfunction

  // Shift register image of a FIFO entry: bit 0 is sent first, parity last.
  function automatic logic [7:0] frame_payload(input logic [6:0] entry);
    frame_payload = {parity7(entry), entry};
  endfunction

  // FIFO storage and bookkeeping
  logic [6:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_drop;

  // Transmitter state
  state_e        r_state;
  logic [7:0]    r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  // Combinational next values
  state_e        w_state_nxt;
  logic [7:0]    w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_empty;
  logic          w_full_now;
  logic          w_baud_end;
  logic [CW-1:0] w_count_nxt;

  assign w_empty    = (r_count == {CW{1'b0}});
  assign w_full_now = (r_count == DEPTH_C);
  assign w_baud_end = (r_baud == BAUD_LAST_C);

  // Frame sequencing: next state, baud/bit counters, shift register and pop.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = 8'd0;
        w_bit_nxt  = 3'd0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_shift_nxt = frame_payload(r_mem[r_rd_ptr]);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = 8'd0;
          w_bit_nxt   = 3'd0;
        end else begin
          w_baud_nxt = r_baud + 8'd1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = 8'd0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = 3'd0;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_nxt = r_baud + 8'd1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = 8'd0;
          w_bit_nxt  = 3'd0;
          // Chain straight into the next start bit when more data waits.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_shift_nxt = frame_payload(r_mem[r_rd_ptr]);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = 8'd0;
        w_bit_nxt   = 3'd0;
      end
    endcase
  end

  // Line level that the next state will present, so o_tx lines up with state.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  // FIFO push/drop decision; a pop in the same cycle frees a slot when full.
  always_comb begin
    w_push      = bus.i_capture && (!w_full_now || w_pop);
    w_drop      = bus.i_capture && w_full_now && !w_pop;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // Transmitter state and registered line/busy outputs.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= 8'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // FIFO pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_full   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_drop  <= w_drop;
    end
  end

  // FIFO storage write; contents are meaningless once the count is reset.
  always_ff @(posedge clk) begin
    if (i_rst_n && w_push) begin
      r_mem[r_wr_ptr] <= {bus.i_overflow, bus.i_data};
    end
  end

  assign bus.o_tx         = r_tx;
  assign bus.o_busy       = r_busy;
  assign bus.o_fifo_count = r_count;
  assign bus.o_fifo_full  = r_full;
  assign bus.o_drop       = r_drop;

endmodule
